// File: rtl/modulator_tx_scheduler.sv
// -----------------------------------------------------------------------------
// modulator_tx_scheduler
//
// Purpose:
//   Lets two message sources share one DigitalModulator. A two-way round-robin
//   arbiter picks a requester. The winner's message, mode and cnt are latched
//   for the whole frame. The send strobe to the modulator is raised and held
//   until the modulator's first symbol tick. FRAME_TICKS symbol ticks are then
//   counted. When the frame ends, the owner gets a one-clk ack and an
//   inter-frame gap of GAP_TICKS symbol ticks is enforced before the next grant.
//
// Ports:
//   clk              system clock, all logic on the rising edge
//   rst              asynchronous, active-low reset
//   sym_tick         one-clk pulse per modulator symbol period
//   req0 / req1      level requests, held by the source until its ack
//   msg0 / msg1      payloads, sampled only at grant
//   mode0 / mode1    modulation modes, sampled only at grant
//   cnt0 / cnt1      carrier divider selects, sampled only at grant
//   ack0 / ack1      one-clk pulse at the end of that requester's frame
//   send             send strobe to the modulator
//   message/mode/cnt frame fields to the modulator, stable for the whole frame
//                    and holding their last value between frames
//   grant            one-hot owner of the current frame, 2'b00 when none
//   busy             high while a frame is loading, transmitting or in the gap
// -----------------------------------------------------------------------------
module modulator_tx_scheduler #(
    parameter int MSG_W       = 5,
    parameter int CNT_W       = 3,
    parameter int FRAME_TICKS = 6,
    parameter int GAP_TICKS   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sym_tick,
    input  logic             req0,
    input  logic             req1,
    input  logic [MSG_W-1:0] msg0,
    input  logic [MSG_W-1:0] msg1,
    input  logic             mode0,
    input  logic             mode1,
    input  logic [CNT_W-1:0] cnt0,
    input  logic [CNT_W-1:0] cnt1,
    output logic             ack0,
    output logic             ack1,
    output logic             send,
    output logic [MSG_W-1:0] message,
    output logic             mode,
    output logic [CNT_W-1:0] cnt,
    output logic [1:0]       grant,
    output logic             busy
);

    // One counter serves both the frame and the gap, so it is sized for the
    // larger of the two and can never wrap inside either.
    localparam int MAX_TICKS = (FRAME_TICKS > GAP_TICKS) ? FRAME_TICKS : GAP_TICKS;
    localparam int CTR_W     = $clog2(MAX_TICKS + 1);

    localparam logic [CTR_W-1:0] CTR_ONE    = CTR_W'(1);
    // The end condition is tested against the count *before* the final tick,
    // so the tick that would make the counter reach the target ends the phase.
    localparam logic [CTR_W-1:0] FRAME_LAST = CTR_W'(FRAME_TICKS - 1);
    localparam logic [CTR_W-1:0] GAP_LAST   = CTR_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_XMIT = 2'd2;
    localparam logic [1:0] ST_GAP  = 2'd3;

    // The state after a frame ends depends only on whether a gap is configured.
    localparam logic [1:0] ST_AFTER_FRAME = (GAP_TICKS > 0) ? ST_GAP : ST_IDLE;

    // ------------------------------------------------------------------
    // Requester-indexed views of the inputs
    // ------------------------------------------------------------------
    logic [1:0]       req_vec;
    logic [1:0]       mode_vec;
    logic [MSG_W-1:0] msg_vec [2];
    logic [CNT_W-1:0] cnt_vec [2];

    assign req_vec  = {req1, req0};
    assign mode_vec = {mode1, mode0};
    assign msg_vec[0] = msg0;
    assign msg_vec[1] = msg1;
    assign cnt_vec[0] = cnt0;
    assign cnt_vec[1] = cnt1;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [1:0]       state_reg,       state_next;
    logic [CTR_W-1:0] counter_reg,     counter_next;
    logic [1:0]       grant_reg,       grant_next;
    logic             owner_reg,       owner_next;
    logic             last_served_reg, last_served_next;
    logic             send_reg,        send_next;
    logic [1:0]       ack_reg,         ack_next;
    logic [MSG_W-1:0] message_reg,     message_next;
    logic             mode_reg,        mode_next;
    logic [CNT_W-1:0] cnt_reg,         cnt_next;

    // ------------------------------------------------------------------
    // Round-robin arbitration
    //   A requester wins if it asks and either the other one is silent or
    //   the other one was served last. With two requesters this yields a
    //   one-hot (or all-zero) winner vector.
    // ------------------------------------------------------------------
    logic [1:0] wins;
    logic       win_idx;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_arb
            assign wins[gi] = req_vec[gi] &&
                              (!req_vec[1 - gi] || (last_served_reg != 1'(gi)));
        end
    endgenerate

    assign win_idx = wins[1];

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next       = state_reg;
        counter_next     = counter_reg;
        grant_next       = grant_reg;
        owner_next       = owner_reg;
        last_served_next = last_served_reg;
        send_next        = send_reg;
        ack_next         = 2'b00;
        message_next     = message_reg;
        mode_next        = mode_reg;
        cnt_next         = cnt_reg;

        case (state_reg)
            ST_IDLE: begin
                if (|req_vec) begin
                    owner_next   = win_idx;
                    grant_next   = wins;
                    message_next = msg_vec[win_idx];
                    mode_next    = mode_vec[win_idx];
                    cnt_next     = cnt_vec[win_idx];
                    send_next    = 1'b1;
                    counter_next = '0;
                    state_next   = ST_LOAD;
                end
            end

            // send is held until the modulator shows it has started a symbol.
            // That first tick is also the frame's first counted tick.
            ST_LOAD: begin
                if (sym_tick) begin
                    send_next    = 1'b0;
                    counter_next = CTR_ONE;
                    state_next   = ST_XMIT;
                end
            end

            ST_XMIT: begin
                if (sym_tick) begin
                    if (counter_reg == FRAME_LAST) begin
                        ack_next         = grant_reg;
                        grant_next       = 2'b00;
                        last_served_next = owner_reg;
                        counter_next     = '0;
                        state_next       = ST_AFTER_FRAME;
                    end else begin
                        counter_next = counter_reg + CTR_ONE;
                    end
                end
            end

            ST_GAP: begin
                if (sym_tick) begin
                    if (counter_reg == GAP_LAST) begin
                        counter_next = '0;
                        state_next   = ST_IDLE;
                    end else begin
                        counter_next = counter_reg + CTR_ONE;
                    end
                end
            end

            default: begin
                state_next   = ST_IDLE;
                counter_next = '0;
                grant_next   = 2'b00;
                send_next    = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers. An asynchronous reset aborts any frame in flight
    // without acknowledging it.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= ST_IDLE;
            counter_reg     <= '0;
            grant_reg       <= 2'b00;
            owner_reg       <= 1'b0;
            last_served_reg <= 1'b1;   // pretend req1 went last so req0 is favoured
            send_reg        <= 1'b0;
            ack_reg         <= 2'b00;
            message_reg     <= '0;
            mode_reg        <= 1'b0;
            cnt_reg         <= '0;
        end else begin
            state_reg       <= state_next;
            counter_reg     <= counter_next;
            grant_reg       <= grant_next;
            owner_reg       <= owner_next;
            last_served_reg <= last_served_next;
            send_reg        <= send_next;
            ack_reg         <= ack_next;
            message_reg     <= message_next;
            mode_reg        <= mode_next;
            cnt_reg         <= cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign ack0    = ack_reg[0];
    assign ack1    = ack_reg[1];
    assign send    = send_reg;
    assign message = message_reg;
    assign mode    = mode_reg;
    assign cnt     = cnt_reg;
    assign grant   = grant_reg;
    assign busy    = (state_reg != ST_IDLE);

endmodule
